// File: rtl/stack_seq_fsm.sv
// stack_seq_fsm: stack-access sequencer for the memory stage.
// Breaks one CALL/INT (push) or RET/RTI (pop) into single-word memory
// accesses across the PC and flags segments. Pops run in the exact reverse
// order of pushes, so the saved image always reads back correctly.
// Optional build macro STACK_SEQ_ERR_EN adds an 'err' output. It pulses
// for a stack request whose direction is ambiguous (mr == mw).
module stack_seq_fsm #(
    parameter int PC_WORDS   = 2,
    parameter int FLAG_WORDS = 1,
    parameter int IDX_W      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stack_pc,
    input  logic             stack_flags,
    input  logic             mr,
    input  logic             mw,
    input  logic             flush,
    output logic [1:0]       seq_state,
    output logic [1:0]       seg_sel,
    output logic [IDX_W-1:0] word_sel,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             stall,
    output logic             done
`ifdef STACK_SEQ_ERR_EN
    ,
    output logic             err
`endif
);

    // The counter holds the index of the next word in the whole sequence.
    localparam int CNT_W = $clog2(PC_WORDS + FLAG_WORDS + 1);

    // Each state names the segment of the next word to issue.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        SEG_PC    = 2'b01,
        SEG_FLAGS = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             op_pc, op_pc_nxt;
    logic             op_fl, op_fl_nxt;
    logic             op_push, op_push_nxt;

    logic             accept;
    logic             issue;
    logic             last;
    logic             cur_pc;
    logic             cur_fl;
    logic             cur_push;
    int               cur_k;
    int               total;
    logic [1:0]       cur_seg;
    logic [IDX_W-1:0] cur_word;
    logic [1:0]       nxt_seg;

    // Total number of words moved for a given set of segment requests.
    function automatic int words_in(input logic pc, input logic fl);
        return (pc ? PC_WORDS : 0) + (fl ? FLAG_WORDS : 0);
    endfunction

    // Segment holding sequence word k. A push writes PC first; a pop reads flags first.
    function automatic logic [1:0] seg_of(input logic pc, input logic fl,
                                          input logic push, input int k);
        if (push)
            return (pc && k < PC_WORDS) ? 2'b01 : 2'b10;
        else
            return (fl && k < FLAG_WORDS) ? 2'b10 : 2'b01;
    endfunction

    // Word index inside its segment for sequence word k.
    // A push counts down within each segment; a pop counts up.
    function automatic logic [IDX_W-1:0] word_of(input logic pc, input logic fl,
                                                 input logic push, input int k);
        int w;
        if (push) begin
            if (pc && k < PC_WORDS)
                w = PC_WORDS - 1 - k;
            else
                w = FLAG_WORDS - 1 - (k - (pc ? PC_WORDS : 0));
        end else begin
            if (fl && k < FLAG_WORDS)
                w = k;
            else
                w = k - (fl ? FLAG_WORDS : 0);
        end
        return IDX_W'(w);
    endfunction

    // State register: sequence position plus the operation latched at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            op_pc   <= 1'b0;
            op_fl   <= 1'b0;
            op_push <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            op_pc   <= op_pc_nxt;
            op_fl   <= op_fl_nxt;
            op_push <= op_push_nxt;
        end
    end

    // Decode the word offered this cycle.
    // In IDLE it comes straight from the inputs; otherwise it comes from the latched operation.
    always_comb begin
        accept = rst_n && (state == IDLE) && start && (stack_pc || stack_flags)
                 && (mr ^ mw) && !flush;
        if (state == IDLE) begin
            cur_pc   = stack_pc;
            cur_fl   = stack_flags;
            cur_push = mw;
            cur_k    = 0;
        end else begin
            cur_pc   = op_pc;
            cur_fl   = op_fl;
            cur_push = op_push;
            cur_k    = int'(cnt);
        end
        issue    = rst_n && !flush && ((state != IDLE) || accept);
        total    = words_in(cur_pc, cur_fl);
        last     = (cur_k == total - 1);
        cur_seg  = seg_of(cur_pc, cur_fl, cur_push, cur_k);
        cur_word = word_of(cur_pc, cur_fl, cur_push, cur_k);
        nxt_seg  = seg_of(cur_pc, cur_fl, cur_push, cur_k + 1);
    end

    // Next-state logic.
    // A flush abandons the sequence; otherwise each issued word advances one step.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        op_pc_nxt   = op_pc;
        op_fl_nxt   = op_fl;
        op_push_nxt = op_push;
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (issue) begin
            if (state == IDLE) begin
                op_pc_nxt   = stack_pc;
                op_fl_nxt   = stack_flags;
                op_push_nxt = mw;
            end
            if (last) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                state_nxt = (nxt_seg == 2'b01) ? SEG_PC : SEG_FLAGS;
                cnt_nxt   = CNT_W'(cur_k + 1);
            end
        end
    end

    // Output decode: strobes and indices exist only while a word is actually issued.
    always_comb begin
        seg_sel  = 2'b00;
        word_sel = '0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        stall    = 1'b0;
        done     = 1'b0;
        if (issue) begin
            seg_sel  = cur_seg;
            word_sel = cur_word;
            mem_wr   = cur_push;
            mem_rd   = !cur_push;
            stall    = !last;
            done     = last;
        end
    end

    assign seq_state = state;

`ifdef STACK_SEQ_ERR_EN
    // Flag a stack request that names no unambiguous direction.
    always_comb begin
        err = rst_n && (state == IDLE) && !flush && start
              && (stack_pc || stack_flags) && !(mr ^ mw);
    end
`endif

endmodule
